// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point add/subtract unit.
//   RM_*   : rounding-mode encodings presented on the rm port
//   FLG_*  : bit positions inside the 4-bit flags vector
//   canon_qnan : canonical quiet NaN pattern {0, all-ones exponent, 1, 0...}
//                for a given exponent/fraction width (formats up to 64 bits)
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;   // round to nearest, ties to even
    localparam logic [1:0] RM_RTZ = 2'b01;   // round toward zero
    localparam logic [1:0] RM_RUP = 2'b10;   // round toward +inf
    localparam logic [1:0] RM_RDN = 2'b11;   // round toward -inf

    localparam int FLG_NV = 3;               // invalid operation
    localparam int FLG_OF = 2;               // overflow
    localparam int FLG_UF = 1;               // underflow
    localparam int FLG_NX = 0;               // inexact

    // Canonical qNaN right-aligned in 64 bits; the caller keeps the low 1+exp_w+man_w bits.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   value : input vector, MSB first
//   count : number of zeros above the most significant set bit (WIDTH when value is 0)
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit is the last one to assign the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CW'(WIDTH - 1 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined IEEE-754 add/subtract with flush-to-zero subnormals,
// four rounding modes, exception flags and a valid/ready handshake.
//   clk, clrn            : clock, synchronous active-high reset
//   in_valid/in_ready    : operation handshake (a, b, sub, rm, in_tag)
//   a, b                 : operands {sign, exp, frac}; sub=1 computes a-b
//   rm                   : rounding mode (fp_pkg RM_*)
//   out_valid/out_ready  : result handshake (result, out_tag, flags)
//   flags                : {invalid, overflow, underflow, inexact} for this result
// Stages: S1 unpack/swap/align, S2 significand add, S3 normalise, S4 round into
// the output registers. All stages move together whenever the output can advance.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    input  logic [1:0]             rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;            // hidden + fraction + guard/round/sticky
    localparam int EW  = EXP_W + 2;            // exponent with room for over/underflow
    localparam int TW  = 2 * MAN_W + 4;        // alignment window, wide enough to lose nothing below sticky
    localparam int LZW = $clog2(SW + 1);

    localparam logic [63:0]      QNAN_FULL = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EW-1:0]    EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};

    logic advance_s;
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic               sign_a_s, sign_b_s;
    logic [EXP_W-1:0]   exp_a_s, exp_b_s;
    logic [MAN_W-1:0]   frac_a_s, frac_b_s;
    logic [MAN_W:0]     sig_a_s, sig_b_s;
    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_snan_s, b_snan_s;
    logic               swap_s;
    logic               big_sign_s;
    logic [EXP_W-1:0]   big_exp_s, small_exp_s, diff_s;
    logic [MAN_W:0]     big_sig_s, small_sig_s;
    logic [TW-1:0]      wide_s;
    logic [SW-1:0]      small_ext_s;
    logic               spec_s, spec_nv_s;
    logic [W-1:0]       spec_res_s;

    assign sign_a_s = a[W-1];
    assign exp_a_s  = a[W-2:MAN_W];
    assign frac_a_s = a[MAN_W-1:0];
    assign sign_b_s = b[W-1] ^ sub;
    assign exp_b_s  = b[W-2:MAN_W];
    assign frac_b_s = b[MAN_W-1:0];

    assign a_nan_s  = (exp_a_s == EXP_ONES) && (frac_a_s != {MAN_W{1'b0}});
    assign b_nan_s  = (exp_b_s == EXP_ONES) && (frac_b_s != {MAN_W{1'b0}});
    assign a_inf_s  = (exp_a_s == EXP_ONES) && (frac_a_s == {MAN_W{1'b0}});
    assign b_inf_s  = (exp_b_s == EXP_ONES) && (frac_b_s == {MAN_W{1'b0}});
    assign a_snan_s = a_nan_s && !frac_a_s[MAN_W-1];
    assign b_snan_s = b_nan_s && !frac_b_s[MAN_W-1];

    // Zero exponent means zero (subnormals flushed), so no hidden bit and no fraction.
    assign sig_a_s = (exp_a_s == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}} : {1'b1, frac_a_s};
    assign sig_b_s = (exp_b_s == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}} : {1'b1, frac_b_s};
    assign swap_s  = {exp_b_s, sig_b_s} > {exp_a_s, sig_a_s};

    // Order operands so the larger magnitude is always "big".
    always_comb begin
        if (swap_s) begin
            big_sign_s  = sign_b_s;
            big_exp_s   = exp_b_s;
            big_sig_s   = sig_b_s;
            small_exp_s = exp_a_s;
            small_sig_s = sig_a_s;
        end else begin
            big_sign_s  = sign_a_s;
            big_exp_s   = exp_a_s;
            big_sig_s   = sig_a_s;
            small_exp_s = exp_b_s;
            small_sig_s = sig_b_s;
        end
    end

    assign diff_s = big_exp_s - small_exp_s;
    assign wide_s = {small_sig_s, {(MAN_W+3){1'b0}}} >> diff_s;

    // Align the smaller significand; very large shifts leave only a sticky bit.
    always_comb begin
        if (32'(diff_s) >= 32'(MAN_W + 3)) begin
            small_ext_s = {{(SW-1){1'b0}}, |small_sig_s};
        end else begin
            small_ext_s = {wide_s[TW-1:MAN_W+1], |wide_s[MAN_W:0]};
        end
    end

    // NaN and infinity operands produce a final result here and skip the arithmetic.
    always_comb begin
        spec_s     = 1'b1;
        spec_nv_s  = 1'b0;
        spec_res_s = QNAN;
        if (a_nan_s || b_nan_s) begin
            spec_nv_s = a_snan_s || b_snan_s;
        end else if (a_inf_s && b_inf_s) begin
            if (sign_a_s != sign_b_s) begin
                spec_nv_s = 1'b1;
            end else begin
                spec_res_s = {sign_a_s, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (a_inf_s) begin
            spec_res_s = {sign_a_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf_s) begin
            spec_res_s = {sign_b_s, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_s = 1'b0;
        end
    end

    logic               s1_valid_r, s1_sign_r, s1_sub_r, s1_spec_r, s1_spec_nv_r;
    logic [EXP_W-1:0]   s1_exp_r;
    logic [SW-1:0]      s1_big_r, s1_small_r;
    logic [1:0]         s1_rm_r;
    logic [TAG_W-1:0]   s1_tag_r;
    logic [W-1:0]       s1_spec_res_r;

    // Stage 1 registers: aligned operands and any special-case result.
    always_ff @(posedge clk) begin
        if (clrn) begin
            s1_valid_r <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r    <= in_valid;
            s1_sign_r     <= big_sign_s;
            s1_sub_r      <= sign_a_s ^ sign_b_s;
            s1_exp_r      <= big_exp_s;
            s1_big_r      <= {big_sig_s, 3'b000};
            s1_small_r    <= small_ext_s;
            s1_rm_r       <= rm;
            s1_tag_r      <= in_tag;
            s1_spec_r     <= spec_s;
            s1_spec_nv_r  <= spec_nv_s;
            s1_spec_res_r <= spec_res_s;
        end
    end

    // ---------------- S2: significand add/subtract ----------------
    logic [SW:0] sum_s;
    // |big| >= |small|, so subtraction never goes negative.
    assign sum_s = s1_sub_r ? ({1'b0, s1_big_r} - {1'b0, s1_small_r})
                            : ({1'b0, s1_big_r} + {1'b0, s1_small_r});

    logic               s2_valid_r, s2_sign_r, s2_sub_r, s2_spec_r, s2_spec_nv_r;
    logic [EXP_W-1:0]   s2_exp_r;
    logic [SW:0]        s2_sum_r;
    logic [1:0]         s2_rm_r;
    logic [TAG_W-1:0]   s2_tag_r;
    logic [W-1:0]       s2_spec_res_r;

    // Stage 2 registers: raw sum with carry.
    always_ff @(posedge clk) begin
        if (clrn) begin
            s2_valid_r <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r    <= s1_valid_r;
            s2_sign_r     <= s1_sign_r;
            s2_sub_r      <= s1_sub_r;
            s2_exp_r      <= s1_exp_r;
            s2_sum_r      <= sum_s;
            s2_rm_r       <= s1_rm_r;
            s2_tag_r      <= s1_tag_r;
            s2_spec_r     <= s1_spec_r;
            s2_spec_nv_r  <= s1_spec_nv_r;
            s2_spec_res_r <= s1_spec_res_r;
        end
    end

    // ---------------- S3: normalise ----------------
    logic [LZW-1:0] lz_s;
    logic [SW-1:0]  norm_s;
    logic [EW-1:0]  exp_n_s;
    logic           zero_s, uf_s;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .value (s2_sum_r[SW-1:0]),
        .count (lz_s)
    );

    // Carry-out shifts right one place (folding the lost bit into sticky); otherwise shift left.
    always_comb begin
        if (s2_sum_r[SW]) begin
            norm_s  = {s2_sum_r[SW:2], s2_sum_r[1] | s2_sum_r[0]};
            exp_n_s = {2'b00, s2_exp_r} + EXP_ONE;
        end else begin
            norm_s  = s2_sum_r[SW-1:0] << lz_s;
            exp_n_s = {2'b00, s2_exp_r} - EW'(lz_s);
        end
    end

    assign zero_s = (s2_sum_r == {(SW+1){1'b0}});
    assign uf_s   = !zero_s && (exp_n_s[EW-1] || (exp_n_s == {EW{1'b0}}));

    logic               s3_valid_r, s3_sign_r, s3_sub_r, s3_spec_r, s3_spec_nv_r;
    logic               s3_zero_r, s3_uf_r;
    logic [EW-1:0]      s3_exp_r;
    logic [SW-1:0]      s3_norm_r;
    logic [1:0]         s3_rm_r;
    logic [TAG_W-1:0]   s3_tag_r;
    logic [W-1:0]       s3_spec_res_r;

    // Stage 3 registers: normalised significand and exponent.
    always_ff @(posedge clk) begin
        if (clrn) begin
            s3_valid_r <= 1'b0;
        end else if (advance_s) begin
            s3_valid_r    <= s2_valid_r;
            s3_sign_r     <= s2_sign_r;
            s3_sub_r      <= s2_sub_r;
            s3_exp_r      <= exp_n_s;
            s3_norm_r     <= norm_s;
            s3_zero_r     <= zero_s;
            s3_uf_r       <= uf_s;
            s3_rm_r       <= s2_rm_r;
            s3_tag_r      <= s2_tag_r;
            s3_spec_r     <= s2_spec_r;
            s3_spec_nv_r  <= s2_spec_nv_r;
            s3_spec_res_r <= s2_spec_res_r;
        end
    end

    // ---------------- S4: round and pack ----------------
    logic [MAN_W:0]   mant_s;
    logic             guard_s, round_s, sticky_s, nx_s, inc_s, ovf_s, zsign_s;
    logic [MAN_W+1:0] rnd_s;
    logic [EW-1:0]    exp_r_s;
    logic [MAN_W-1:0] frac_r_s;
    logic [W-1:0]     res_s;
    logic [3:0]       flg_s;

    assign mant_s   = s3_norm_r[SW-1:3];
    assign guard_s  = s3_norm_r[2];
    assign round_s  = s3_norm_r[1];
    assign sticky_s = s3_norm_r[0];
    assign nx_s     = guard_s | round_s | sticky_s;

    // Round-increment decision for the selected mode.
    always_comb begin
        case (s3_rm_r)
            RM_RNE:  inc_s = guard_s & (round_s | sticky_s | mant_s[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RUP:  inc_s = !s3_sign_r & nx_s;
            RM_RDN:  inc_s = s3_sign_r & nx_s;
            default: inc_s = 1'b0;
        endcase
    end

    assign rnd_s = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, inc_s};

    // Mantissa carry from rounding leaves 1.000... and bumps the exponent.
    always_comb begin
        if (rnd_s[MAN_W+1]) begin
            exp_r_s  = s3_exp_r + EXP_ONE;
            frac_r_s = rnd_s[MAN_W:1];
        end else begin
            exp_r_s  = s3_exp_r;
            frac_r_s = rnd_s[MAN_W-1:0];
        end
    end

    assign ovf_s   = exp_r_s >= {2'b00, EXP_ONES};
    // Exact cancellation gives +0 except in RDN; like-signed zeros keep their sign.
    assign zsign_s = s3_sub_r ? (s3_rm_r == RM_RDN) : s3_sign_r;

    // Final result and flag selection, specials taking priority.
    always_comb begin
        res_s = {W{1'b0}};
        flg_s = 4'b0000;
        if (s3_spec_r) begin
            res_s         = s3_spec_res_r;
            flg_s[FLG_NV] = s3_spec_nv_r;
        end else if (s3_zero_r) begin
            res_s = {zsign_s, {(W-1){1'b0}}};
        end else if (s3_uf_r) begin
            res_s         = {s3_sign_r, {(W-1){1'b0}}};
            flg_s[FLG_UF] = 1'b1;
            flg_s[FLG_NX] = 1'b1;
        end else if (ovf_s) begin
            flg_s[FLG_OF] = 1'b1;
            flg_s[FLG_NX] = 1'b1;
            case (s3_rm_r)
                RM_RNE:  res_s = {s3_sign_r, EXP_ONES, {MAN_W{1'b0}}};
                RM_RTZ:  res_s = {s3_sign_r, EXP_ONES - 1'b1, {MAN_W{1'b1}}};
                RM_RUP:  res_s = s3_sign_r ? {1'b1, EXP_ONES - 1'b1, {MAN_W{1'b1}}}
                                           : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                RM_RDN:  res_s = s3_sign_r ? {1'b1, EXP_ONES, {MAN_W{1'b0}}}
                                           : {1'b0, EXP_ONES - 1'b1, {MAN_W{1'b1}}};
                default: res_s = {s3_sign_r, EXP_ONES, {MAN_W{1'b0}}};
            endcase
        end else begin
            res_s         = {s3_sign_r, exp_r_s[EXP_W-1:0], frac_r_s};
            flg_s[FLG_NX] = nx_s;
        end
    end

    // Output registers; they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (clrn) begin
            out_valid <= 1'b0;
            result    <= {W{1'b0}};
            out_tag   <= {TAG_W{1'b0}};
            flags     <= 4'b0000;
        end else if (advance_s) begin
            out_valid <= s3_valid_r;
            result    <= res_s;
            out_tag   <= s3_tag_r;
            flags     <= flg_s;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: a single-precision instance and a
// half-precision instance sharing clock and reset.
module tb_fp_addsub_pipe;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;
    localparam logic [3:0] F_NV = 4'b1000;
    localparam logic [3:0] F_OF = 4'b0100;
    localparam logic [3:0] F_UF = 4'b0010;
    localparam logic [3:0] F_NX = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  rm;
    logic [3:0]  in_tag, out_tag, flags;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [1:0]  h_rm;
    logic [3:0]  h_in_tag, h_out_tag, h_flags;

    int n_vec = 0;
    int n_err = 0;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .rm(rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .clrn(clrn), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .rm(h_rm), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
        .out_tag(h_out_tag), .flags(h_flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string nm, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [1:0] rv, input logic [3:0] tv,
                        input logic [31:0] er, input logic [3:0] ef);
        int cyc;
        @(negedge clk);
        a = av; b = bv; sub = sv; rm = rv; in_tag = tv;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "/latency"}, 64'(cyc), 64'd4);
        chk({nm, "/result"}, 64'(result), 64'(er));
        chk({nm, "/flags"}, 64'(flags), 64'(ef));
        chk({nm, "/tag"}, 64'(out_tag), 64'(tv));
    endtask

    task automatic op16(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic [15:0] er, input logic [3:0] ef);
        int cyc;
        @(negedge clk);
        h_a = av; h_b = bv; h_sub = sv; h_rm = RNE; h_in_tag = 4'd9;
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        cyc = 1;
        while (!h_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "/latency"}, 64'(cyc), 64'd4);
        chk({nm, "/result"}, 64'(h_result), 64'(er));
        chk({nm, "/flags"}, 64'(h_flags), 64'(ef));
    endtask

    logic [31:0] bp_b [6];
    logic [31:0] bp_r [6];
    logic [31:0] held;
    int sent, got, extra;

    initial begin
        bp_b[0] = 32'h00000000; bp_r[0] = 32'h3F800000;
        bp_b[1] = 32'h3F800000; bp_r[1] = 32'h40000000;
        bp_b[2] = 32'h40000000; bp_r[2] = 32'h40400000;
        bp_b[3] = 32'h40400000; bp_r[3] = 32'h40800000;
        bp_b[4] = 32'h40800000; bp_r[4] = 32'h40A00000;
        bp_b[5] = 32'h40A00000; bp_r[5] = 32'h40C00000;
        held = 32'h0;

        clrn = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
        sub = 1'b0; rm = RNE; in_tag = 4'd0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = 16'h0; h_b = 16'h0;
        h_sub = 1'b0; h_rm = RNE; h_in_tag = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/out_valid", 64'(out_valid), 64'd0);
        chk("rst/result", 64'(result), 64'd0);
        chk("rst/flags", 64'(flags), 64'd0);
        chk("rst/out_tag", 64'(out_tag), 64'd0);
        chk("rst/in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        clrn = 1'b0;

        op32("add",        32'h3F000000, 32'h3E800000, 1'b0, RNE, 4'd5,  32'h3F400000, 4'b0000);
        op32("cancel_rne", 32'h3F800000, 32'h3F800000, 1'b1, RNE, 4'd1,  32'h00000000, 4'b0000);
        op32("cancel_rdn", 32'h3F800000, 32'h3F800000, 1'b1, RDN, 4'd2,  32'h80000000, 4'b0000);
        op32("tie_even",   32'h3F800000, 32'h33800000, 1'b0, RNE, 4'd3,  32'h3F800000, F_NX);
        op32("lsb_exact",  32'h3F800000, 32'h34000000, 1'b0, RNE, 4'd4,  32'h3F800001, 4'b0000);
        op32("above_half", 32'h3F800000, 32'h33800001, 1'b0, RNE, 4'd6,  32'h3F800001, F_NX);
        op32("rtz_trunc",  32'h3F800000, 32'h33800001, 1'b0, RTZ, 4'd7,  32'h3F800000, F_NX);
        op32("ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE, 4'd8,  32'h7F800000, F_OF | F_NX);
        op32("ovf_rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RTZ, 4'd9,  32'h7F7FFFFF, F_OF | F_NX);
        op32("ovf_rup_neg",32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, RUP, 4'd10, 32'hFF7FFFFF, F_OF | F_NX);
        op32("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, RNE, 4'd11, 32'h7FC00000, F_NV);
        op32("snan",       32'h7FA00000, 32'h3F800000, 1'b0, RNE, 4'd12, 32'h7FC00000, F_NV);
        op32("qnan",       32'h3F800000, 32'h7FC00001, 1'b0, RNE, 4'd13, 32'h7FC00000, 4'b0000);
        op32("inf_finite", 32'hFF800000, 32'h3F800000, 1'b0, RNE, 4'd14, 32'hFF800000, 4'b0000);
        op32("neg_zeros",  32'h80000000, 32'h80000000, 1'b0, RNE, 4'd15, 32'h80000000, 4'b0000);
        op32("norm_left",  32'h3F800000, 32'h3F000000, 1'b1, RNE, 4'd0,  32'h3F000000, 4'b0000);
        op32("underflow",  32'h00C00000, 32'h00800000, 1'b1, RNE, 4'd1,  32'h00000000, F_UF | F_NX);

        op16("h_two", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        op16("h_ovf", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, F_OF | F_NX);
        op16("h_ftz", 16'h0400, 16'h03FF, 1'b1, 16'h0400, 4'b0000);

        // Drain, then stream six ops with a three-cycle consumer stall.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        sent = 0; got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 7);
            if (sent < 6) begin
                a = 32'h3F800000; b = bp_b[sent]; sub = 1'b0; rm = RNE;
                in_tag = 4'(sent); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 5) held = result;
            if (!out_ready && out_valid) begin
                chk("bp/stall_in_ready", 64'(in_ready), 64'd0);
                chk("bp/stall_hold", 64'(result), 64'(held));
            end
            if (out_valid && out_ready) begin
                chk("bp/tag", 64'(out_tag), 64'(got));
                chk("bp/result", 64'(result), 64'(bp_r[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp/count", 64'(got), 64'd6);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("bp/no_duplicate", 64'(extra), 64'd0);

        // Reset with three ops in flight; the oldest would otherwise emerge at the reset edge.
        repeat (3) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h3F800000; in_tag = 4'd7; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; clrn = 1'b1;
        @(posedge clk); #1;
        chk("flush/out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        clrn = 1'b0;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("flush/no_survivor", 64'(extra), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
